// File: rtl/printf_arbiter.sv
// Round-robin arbiter that serialises per-channel printf messages onto a byte-wide
// UART transmit handshake, with an optional ASCII channel tag per message.

module printf_arbiter_lane #(
  parameter int MW = 32
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          arm_i,
  input  logic          req_i,
  input  logic [MW-1:0] data_i,
  input  logic          grant_i,
  input  logic          clr_i,
  output logic          pending_o,
  output logic [MW-1:0] hold_o,
  output logic          ovf_o
);
  logic          req_q, pend_q, ovf_q;
  logic          pend_d, ovf_d;
  logic [MW-1:0] hold_q;
  logic          rise, cap;

  assign rise = req_i & ~req_q & arm_i;
  // A rise on the grant edge refills the slot being drained, so it is not a drop.
  assign cap    = rise & (~pend_q | grant_i);
  assign pend_d = cap | (pend_q & ~grant_i);
  assign ovf_d  = clr_i ? 1'b0 : (ovf_q | (rise & pend_q & ~grant_i));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      req_q  <= 1'b0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      req_q  <= req_i;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      if (cap) hold_q <= data_i;
    end
  end

  assign pending_o = pend_q;
  assign hold_o    = hold_q;
  assign ovf_o     = ovf_q;
endmodule

module printf_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int DATA_NUM = 4,
  parameter int TAG_EN   = 1
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic [NUM_CH-1:0]          printf_i,
  input  logic [NUM_CH*DATA_NUM*8-1:0] send_data_i,
  input  logic                       overflow_clr_i,
  input  logic                       tx_data_ready_i,
  output logic [7:0]                 tx_data_o,
  output logic                       tx_data_valid_o,
  output logic                       busy_o,
  output logic [NUM_CH-1:0]          overflow_o
);
  localparam int MW = DATA_NUM * 8;
  localparam int NB = DATA_NUM + ((TAG_EN != 0) ? 1 : 0);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BW = $clog2(NB + 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  state_e                     state_q, state_d;
  logic                       arm_q;
  logic [CW-1:0]              last_q, last_d;
  logic [BW-1:0]              cnt_q, cnt_d;
  logic [MW-1:0]              shift_q, shift_d;
  logic [7:0]                 tx_data_q, tx_data_d;
  logic                       tx_valid_q, tx_valid_d;
  logic                       busy_q, busy_d;

  logic [NUM_CH-1:0]          pending, grant_oh;
  logic [NUM_CH-1:0][MW-1:0]  hold;
  logic [CW-1:0]              gsel;
  logic                       gfound;
  logic [7:0]                 gsel8, tag;
  logic                       last_byte;
  int                         idx;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    printf_arbiter_lane #(.MW(MW)) u_lane (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .arm_i     (arm_q),
      .req_i     (printf_i[c]),
      .data_i    (send_data_i[c*MW +: MW]),
      .grant_i   (grant_oh[c]),
      .clr_i     (overflow_clr_i),
      .pending_o (pending[c]),
      .hold_o    (hold[c]),
      .ovf_o     (overflow_o[c])
    );
  end

  // Rotating priority: first pending channel strictly after the last grant.
  always_comb begin
    gsel   = last_q;
    gfound = 1'b0;
    idx    = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last_q) + i) % NUM_CH;
      if (!gfound && pending[idx]) begin
        gfound = 1'b1;
        gsel   = CW'(idx);
      end
    end
  end

  assign grant_oh  = (state_q == IDLE && gfound) ? (NUM_CH'(1) << gsel) : '0;
  assign gsel8     = 8'(gsel);
  assign tag       = (gsel8 < 8'd10) ? (8'h30 + gsel8) : (8'h37 + gsel8);
  assign last_byte = (cnt_q == BW'(NB - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      arm_q      <= 1'b0;
      last_q     <= CW'(NUM_CH - 1);
      cnt_q      <= '0;
      shift_q    <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_q      <= 1'b1;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gfound) state_d = SEND;
      SEND:    if (tx_valid_q && tx_data_ready_i && last_byte) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_data_d  = tx_data_q;
    tx_valid_d = (state_d == SEND);
    busy_d     = (state_d != IDLE);
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    case (state_q)
      IDLE: if (gfound) begin
        last_d = gsel;
        cnt_d  = '0;
        if (TAG_EN != 0) begin
          tx_data_d = tag;
          shift_d   = hold[gsel];
        end else begin
          tx_data_d = hold[gsel][MW-1 -: 8];
          shift_d   = hold[gsel] << 8;
        end
      end
      SEND: if (tx_valid_q && tx_data_ready_i && !last_byte) begin
        cnt_d     = cnt_q + BW'(1);
        tx_data_d = shift_q[MW-1 -: 8];
        shift_d   = shift_q << 8;
      end
      default: ;
    endcase
  end

  assign tx_data_o       = tx_data_q;
  assign tx_data_valid_o = tx_valid_q;
  assign busy_o          = busy_q;
endmodule

// File: tb/tb_printf_arbiter.sv
// Scoreboard bench for printf_arbiter: directed requests push expected bytes, a
// negedge monitor pops and compares every accepted byte and checks stalled bytes.

module tb_printf_arbiter;
  localparam int NUM_CH = 4, DATA_NUM = 2, TAG_EN = 1;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic [NUM_CH-1:0]            printf_i = '0;
  logic [NUM_CH*DATA_NUM*8-1:0] send_data = '0;
  logic                         ovf_clr = 1'b0;
  logic                         ready = 1'b0;
  logic [7:0]                   tx_data;
  logic                         tx_valid;
  logic                         busy;
  logic [NUM_CH-1:0]            overflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  printf_arbiter #(.NUM_CH(NUM_CH), .DATA_NUM(DATA_NUM), .TAG_EN(TAG_EN)) dut (
    .sys_clk         (clk),
    .sys_rst_n       (rst_n),
    .printf_i        (printf_i),
    .send_data_i     (send_data),
    .overflow_clr_i  (ovf_clr),
    .tx_data_ready_i (ready),
    .tx_data_o       (tx_data),
    .tx_data_valid_o (tx_valid),
    .busy_o          (busy),
    .overflow_o      (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop on handshake, compare the head while stalled.
  always @(negedge clk) begin
    if (tx_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got byte %0h expected none at %0t", tx_data, $time);
      end else if (ready) begin
        chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end else begin
        chk("tx_stall", {24'h0, tx_data}, {24'h0, exp_q[0]});
      end
    end
  end

  task automatic set_data(input int c, input logic [15:0] v);
    send_data[c*16 +: 16] = v;
  endtask

  task automatic push_msg(input int c, input logic [15:0] d);
    exp_q.push_back(8'h30 + 8'(c));
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic wait_idle(input int max);
    bit done = 0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (!busy && exp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_valid(input int max);
    bit done = 0;
    for (int i = 0; i < max; i++) begin
      if (tx_valid) begin
        done = 1;
        break;
      end
      tick();
    end
    if (!done) chk("wait_valid_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int vcount;
    // Reset state
    do_reset();
    chk("rst_valid", {31'h0, tx_valid}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_data", {24'h0, tx_data}, 32'h00);
    chk("rst_ovf", {28'h0, overflow}, 32'h0);

    // Single message on ch2, ready held high: exact cycle timing
    ready = 1'b1;
    set_data(2, 16'h4142);
    printf_i[2] = 1'b1;
    push_msg(2, 16'h4142);
    tick();
    chk("t29_capture_valid", {31'h0, tx_valid}, 32'd0);
    tick();
    chk("t29_b0_valid", {31'h0, tx_valid}, 32'd1);
    chk("t29_b0_data", {24'h0, tx_data}, 32'h32);
    chk("t29_busy", {31'h0, busy}, 32'd1);
    tick();
    chk("t29_b1_data", {24'h0, tx_data}, 32'h41);
    tick();
    chk("t29_b2_data", {24'h0, tx_data}, 32'h42);
    tick();
    chk("t29_gap_valid", {31'h0, tx_valid}, 32'd0);
    chk("t29_gap_busy", {31'h0, busy}, 32'd1);
    tick();
    chk("t29_idle_busy", {31'h0, busy}, 32'd0);
    printf_i[2] = 1'b0;
    repeat (3) tick();

    // Overflow: two ch1 rises while ch0 is stalled in SEND
    ready = 1'b0;
    set_data(0, 16'h1112);
    printf_i[0] = 1'b1;
    push_msg(0, 16'h1112);
    repeat (3) tick();
    set_data(1, 16'h2122);
    printf_i[1] = 1'b1;
    push_msg(1, 16'h2122);
    tick();
    printf_i[1] = 1'b0;
    tick();
    set_data(1, 16'h2F2F);
    printf_i[1] = 1'b1;
    tick();
    chk("t32_ovf_set", {28'h0, overflow}, 32'h2);
    ready = 1'b1;
    wait_idle(100);
    chk("t32_ovf_sticky", {28'h0, overflow}, 32'h2);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t32_ovf_clr", {28'h0, overflow}, 32'h0);
    printf_i = '0;
    repeat (3) tick();

    // Ready pattern 1,0,0,1 during SEND on ch3
    ready = 1'b0;
    set_data(3, 16'h5A3C);
    printf_i[3] = 1'b1;
    push_msg(3, 16'h5A3C);
    wait_valid(20);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    tick();
    ready = 1'b1;
    wait_idle(100);
    printf_i = '0;
    repeat (3) tick();

    // Round robin from fresh reset: 0,1,3 then wrap to 0 before 3
    do_reset();
    set_data(0, 16'h0A0B);
    set_data(1, 16'h1A1B);
    set_data(3, 16'h3A3B);
    printf_i = 4'b1011;
    push_msg(0, 16'h0A0B);
    push_msg(1, 16'h1A1B);
    push_msg(3, 16'h3A3B);
    wait_idle(200);
    printf_i = '0;
    repeat (2) tick();
    set_data(0, 16'hC0C1);
    set_data(3, 16'hD3D4);
    printf_i = 4'b1001;
    push_msg(0, 16'hC0C1);
    push_msg(3, 16'hD3D4);
    wait_idle(200);
    chk("t30_queue_drained", exp_q.size(), 32'd0);
    printf_i = '0;
    repeat (2) tick();

    // Reset mid-message after second byte; held request ignored after release
    set_data(1, 16'h7172);
    printf_i[1] = 1'b1;
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h71);
    wait_valid(20);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t33_rst_valid", {31'h0, tx_valid}, 32'd0);
    chk("t33_rst_data", {24'h0, tx_data}, 32'h00);
    chk("t33_rst_busy", {31'h0, busy}, 32'd0);
    chk("t33_rst_ovf", {28'h0, overflow}, 32'h0);
    chk("t33_bytes_consumed", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_valid || busy) vcount++;
    end
    chk("t33_no_msg_after_release", vcount, 32'd0);
    printf_i = '0;
    repeat (2) tick();
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/printf_arbiter.md
PRINTF_ARBITER -- requirements
Module: printf_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent printf source channels (1..16).
REQ-002 SHALL have parameter DATA_NUM, default 4: bytes per message per channel (1..16).
REQ-003 SHALL have parameter TAG_EN, default 1: when 1, each message is preceded by one tag byte, ASCII '0'+channel index (channels 10..15 use 'A'..'F').
REQ-004 SHALL have port sys_clk  in  1  the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port sys_rst_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port printf_i  in  NUM_CH  per-channel send request; a 0->1 transition requests one message.
REQ-007 SHALL have port send_data_i  in  NUM_CH*DATA_NUM*8  channel c message at bits [c*DATA_NUM*8 +: DATA_NUM*8].
REQ-008 SHALL have port overflow_clr_i  in  1  pulse that clears all overflow_o bits.
REQ-009 SHALL have port tx_data_ready_i  in  1  UART transmitter can accept a byte.
REQ-010 SHALL have port tx_data_o  out  8  byte offered to the UART transmitter.
REQ-011 SHALL have port tx_data_valid_o  out  1  tx_data_o is valid.
REQ-012 SHALL have port busy_o  out  1  high whenever the FSM is not in IDLE.
REQ-013 SHALL have port overflow_o  out  NUM_CH  sticky per-channel dropped-request flag.

Function
REQ-014 SHALL register printf_i each cycle and detect rise = printf_i & ~printf_q per channel; steady high or level toggles low never request.
REQ-015 SHALL, on a rise for channel c with pending[c]=0, capture channel c's send_data_i slice into hold[c] and set pending[c], both at the same edge.
REQ-016 SHALL, on a rise for channel c with pending[c]=1, keep hold[c] unchanged and set overflow_o[c]; the new request is dropped.
REQ-017 SHALL implement FSM states IDLE, SEND, GAP.
REQ-018 SHALL, in IDLE with any pending bit set, grant the lowest pending channel at or after (last_grant+1) modulo NUM_CH, wrapping past NUM_CH-1 to 0; last_grant resets to NUM_CH-1, so channel 0 has first priority.
REQ-019 SHALL, at the grant edge, copy hold[g] into the shift register, clear pending[g], record last_grant=g, reset byte counter, and enter SEND.
REQ-020 SHALL, when a rise for channel g coincides with its grant edge, treat the rise as a new request (pending[g] stays 1 with new data) without setting overflow.
REQ-021 SHALL, in SEND, drive tx_data_valid_o=1; byte order: tag (if TAG_EN), then message MSB byte [DATA_NUM*8-1 -: 8] first down to byte 0.
REQ-022 SHALL advance to the next byte only on an edge with tx_data_valid_o & tx_data_ready_i; tx_data_o SHALL remain stable while valid and not ready.
REQ-023 SHALL, after the last byte is accepted, enter GAP for exactly one cycle with tx_data_valid_o=0, then IDLE.
REQ-024 SHALL produce tx_data_valid_o high two edges after the edge that samples a rise (capture edge, grant edge).
REQ-025 SHALL make overflow_clr_i take priority over a simultaneous overflow set in the same cycle.
REQ-026 SHALL register all outputs; no combinational path from inputs to outputs.

Reset
REQ-027 SHALL, on sys_rst_n low, immediately clear state to IDLE, pending, hold, printf_q, overflow_o, counter, and drive tx_data_valid_o=0, tx_data_o=8'h00, busy_o=0, even mid-message.
REQ-028 SHALL, after reset release, ignore printf_i already high (printf_q resets to 0 SHALL NOT cause this: printf_q loads printf_i on first edge and rise is masked for that first edge).

Verification
REQ-029 SHALL verify: NUM_CH=4, DATA_NUM=2, TAG_EN=1, ch2 data 16'h4142, ready held 1 -> bytes 8'h32, 8'h41, 8'h42 on consecutive cycles, then one GAP cycle.
REQ-030 SHALL verify: rises on ch0, ch1, ch3 same cycle -> messages sent in order 0,1,3; subsequent rises on ch0 and ch3 together after that -> ch0 first (wrap from last_grant=3).
REQ-031 SHALL verify: ready toggled 1,0,0,1 during SEND -> tx_data_o unchanged while ready=0, no byte lost or duplicated.
REQ-032 SHALL verify: two rises on ch1 while ch0 message in flight -> ch1 sends first-captured data only, overflow_o=4'b0010; overflow_clr_i pulse -> 4'b0000.
REQ-033 SHALL verify: sys_rst_n asserted after second byte of a message -> valid drops without clock edge, no residual bytes after release, printf_i held high through release produces no message.
